// File: rtl/viterbi_pkg.sv
// Shared types and trellis helpers for the K=3, rate-1/2 Viterbi decoder (4 states).
// State encoding is {newest bit, older bit}.
package viterbi_pkg;

  localparam int unsigned NUM_STATES   = 4;
  localparam int unsigned SW           = 2;
  localparam int unsigned PM_W_DEFAULT = 8;

  typedef logic [SW-1:0] state_t;

  typedef enum logic [1:0] {
    StCollect,
    StSelect,
    StTrace,
    StEmit
  } fsm_e;

  // Forward transition on input bit u.
  function automatic state_t next_state(input state_t s, input logic u);
    return {u, s[1]};
  endfunction

  // Predecessor of s given the stored survivor decision (predecessor LSB).
  function automatic state_t pred_state(input state_t s, input logic dec);
    return {s[0], dec};
  endfunction

endpackage

// File: rtl/viterbi_traceback_if.sv
// Stage-input / decoded-bit-output bundle between the survivor stages, traceback and consumer.
// The master side drives stage decisions and accepts decoded bits.
interface viterbi_traceback_if
  import viterbi_pkg::*;
#(
  parameter int unsigned PM_W = PM_W_DEFAULT
);

  logic                  in_valid;
  logic                  in_ready;
  logic [NUM_STATES-1:0] in_dec;
  logic                  in_last;
  logic signed [PM_W-1:0] pm0;
  logic signed [PM_W-1:0] pm1;
  logic signed [PM_W-1:0] pm2;
  logic signed [PM_W-1:0] pm3;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_bit;
  logic                  out_last;
  logic                  frame_err;

  modport master (
    output in_valid, in_dec, in_last, pm0, pm1, pm2, pm3, out_ready,
    input  in_ready, out_valid, out_bit, out_last, frame_err
  );

  modport slave (
    input  in_valid, in_dec, in_last, pm0, pm1, pm2, pm3, out_ready,
    output in_ready, out_valid, out_bit, out_last, frame_err
  );

endinterface

// File: rtl/viterbi_min4.sv
// Combinational argmin over four signed path metrics; ties resolve to the lowest index.
module viterbi_min4
  import viterbi_pkg::*;
#(
  parameter int unsigned PM_W = PM_W_DEFAULT
) (
  input  logic signed [PM_W-1:0] pm0_i,
  input  logic signed [PM_W-1:0] pm1_i,
  input  logic signed [PM_W-1:0] pm2_i,
  input  logic signed [PM_W-1:0] pm3_i,
  output state_t                 idx_o
);

  logic                   sel01;
  logic                   sel23;
  logic signed [PM_W-1:0] min01;
  logic signed [PM_W-1:0] min23;

  // Strict less-than at both levels keeps the lower index on equality.
  always_comb begin
    sel01 = (pm1_i < pm0_i);
    sel23 = (pm3_i < pm2_i);
    min01 = sel01 ? pm1_i : pm0_i;
    min23 = sel23 ? pm3_i : pm2_i;
    if (min23 < min01) begin
      idx_o = {1'b1, sel23};
    end else begin
      idx_o = {1'b0, sel01};
    end
  end

endmodule

// File: rtl/viterbi_traceback.sv
// Frame buffer, best-state selection and traceback for the 4-state Viterbi decoder.
// Decoded bits are replayed in forward order over a valid/ready handshake.
module viterbi_traceback
  import viterbi_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned PM_W      = PM_W_DEFAULT,
  parameter int unsigned AW        = 6
) (
  input logic                  CLK,
  input logic                  RST,
  viterbi_traceback_if.slave   bus_io
);

  localparam int unsigned    Depth   = 2 ** AW;
  localparam logic [AW-1:0]  LastIdx = AW'(FRAME_LEN - 1);

  fsm_e                   state_q;
  logic [AW-1:0]          cnt_q;
  logic [AW-1:0]          nm1_q;
  logic [AW-1:0]          ptr_q;
  logic [AW-1:0]          rd_q;
  state_t                 cur_q;
  logic signed [PM_W-1:0] pm0_q;
  logic signed [PM_W-1:0] pm1_q;
  logic signed [PM_W-1:0] pm2_q;
  logic signed [PM_W-1:0] pm3_q;
  logic                   in_ready_q;
  logic                   out_valid_q;
  logic                   out_bit_q;
  logic                   out_last_q;
  logic                   frame_err_q;

  logic [NUM_STATES-1:0]  dec_mem [Depth];
  logic                   obuf_mem [Depth];

  state_t                 best_state;
  logic                   trace_dec;
  logic                   in_fire;
  logic                   close_frame;
  logic [AW-1:0]          rd_nxt;

  viterbi_min4 #(
    .PM_W (PM_W)
  ) u_min4 (
    .pm0_i (pm0_q),
    .pm1_i (pm1_q),
    .pm2_i (pm2_q),
    .pm3_i (pm3_q),
    .idx_o (best_state)
  );

  assign trace_dec   = dec_mem[ptr_q][cur_q];
  assign in_fire     = (state_q == StCollect) && bus_io.in_valid;
  assign close_frame = in_fire && (bus_io.in_last || (cnt_q == LastIdx));
  assign rd_nxt      = rd_q + AW'(1);

  always_ff @(posedge CLK) begin
    if (in_fire) begin
      dec_mem[cnt_q] <= bus_io.in_dec;
    end
    if (state_q == StTrace) begin
      obuf_mem[ptr_q] <= cur_q[1];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StCollect;
      cnt_q       <= '0;
      nm1_q       <= '0;
      ptr_q       <= '0;
      rd_q        <= '0;
      cur_q       <= '0;
      pm0_q       <= '0;
      pm1_q       <= '0;
      pm2_q       <= '0;
      pm3_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_last_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      unique case (state_q)
        StCollect: begin
          if (close_frame) begin
            nm1_q       <= cnt_q;
            pm0_q       <= bus_io.pm0;
            pm1_q       <= bus_io.pm1;
            pm2_q       <= bus_io.pm2;
            pm3_q       <= bus_io.pm3;
            frame_err_q <= ~bus_io.in_last;
            in_ready_q  <= 1'b0;
            state_q     <= StSelect;
          end else if (in_fire) begin
            cnt_q <= cnt_q + AW'(1);
          end
        end
        StSelect: begin
          cur_q   <= best_state;
          ptr_q   <= nm1_q;
          state_q <= StTrace;
        end
        StTrace: begin
          cur_q <= pred_state(cur_q, trace_dec);
          if (ptr_q == '0) begin
            // obuf[0] is written on this same edge, so present it straight from cur.
            rd_q        <= '0;
            out_valid_q <= 1'b1;
            out_bit_q   <= cur_q[1];
            out_last_q  <= (nm1_q == '0);
            state_q     <= StEmit;
          end else begin
            ptr_q <= ptr_q - AW'(1);
          end
        end
        StEmit: begin
          if (out_valid_q && bus_io.out_ready) begin
            if (rd_q == nm1_q) begin
              out_valid_q <= 1'b0;
              out_bit_q   <= 1'b0;
              out_last_q  <= 1'b0;
              cnt_q       <= '0;
              in_ready_q  <= 1'b1;
              state_q     <= StCollect;
            end else begin
              rd_q       <= rd_nxt;
              out_bit_q  <= obuf_mem[rd_nxt];
              out_last_q <= (rd_nxt == nm1_q);
            end
          end
        end
        default: state_q <= StCollect;
      endcase
    end
  end

  assign bus_io.in_ready  = in_ready_q;
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.out_bit   = out_bit_q;
  assign bus_io.out_last  = out_last_q;
  assign bus_io.frame_err = frame_err_q;

endmodule

// File: tb/tb_viterbi_traceback.sv
// Directed bench for viterbi_traceback: hand-traced frames, backpressure, overflow and reset.
module tb_viterbi_traceback;

  localparam int unsigned FrameLen = 16;
  localparam int unsigned PmW      = 8;
  localparam int unsigned Aw       = 6;

  logic clk;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  // Results of the most recent collect() call.
  logic [63:0] r_bits;
  int          r_nb;
  int          r_lastpos;
  int          r_lat;
  int          r_unstable;
  int          r_rdyhi;
  int          r_ferrcnt;
  int          r_ferrc1;

  viterbi_traceback_if #(.PM_W(PmW)) bus ();

  viterbi_traceback #(
    .FRAME_LEN (FrameLen),
    .PM_W      (PmW),
    .AW        (Aw)
  ) dut (
    .CLK    (clk),
    .RST    (rst),
    .bus_io (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic send_frame(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                            input logic [3:0] d3, input logic signed [7:0] p0,
                            input logic signed [7:0] p1, input logic signed [7:0] p2,
                            input logic signed [7:0] p3);
    logic [3:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_dec   = d[i];
      bus.in_last  = (i == 3);
      bus.pm0 = p0; bus.pm1 = p1; bus.pm2 = p2; bus.pm3 = p3;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Starts in the cycle after the final input beat; cycle 1 is that cycle.
  task automatic collect(input bit toggle);
    logic pb, pl;
    bit   held;
    r_bits = '0; r_nb = 0; r_lastpos = -1; r_lat = -1;
    r_unstable = 0; r_rdyhi = 0; r_ferrcnt = 0; r_ferrc1 = 0;
    held = 0; pb = 0; pl = 0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      bus.out_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
      @(negedge clk);
      if (bus.in_ready === 1'b1) r_rdyhi++;
      if (bus.frame_err === 1'b1) begin
        r_ferrcnt++;
        if (cyc == 1) r_ferrc1 = 1;
      end
      if (bus.out_valid === 1'b1) begin
        if (r_lat < 0) r_lat = cyc;
        if (held && (bus.out_bit !== pb || bus.out_last !== pl)) r_unstable++;
        if (bus.out_ready) begin
          if (r_nb < 64) r_bits[r_nb] = bus.out_bit;
          if (bus.out_last === 1'b1) r_lastpos = r_nb;
          r_nb++;
          held = 0;
        end else begin
          held = 1; pb = bus.out_bit; pl = bus.out_last;
        end
      end
      @(posedge clk); #1;
      if (r_lastpos >= 0) break;
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++;
      $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.out_bit !== 1'b0) begin miscompares++;
      $display("FAIL reset_out_bit: got %b want 0", bus.out_bit); end
    vectors++; if (bus.out_last !== 1'b0) begin miscompares++;
      $display("FAIL reset_out_last: got %b want 0", bus.out_last); end
    vectors++; if (bus.frame_err !== 1'b0) begin miscompares++;
      $display("FAIL reset_frame_err: got %b want 0", bus.frame_err); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_all_zero();
    send_frame(4'b0000, 4'b0000, 4'b0000, 4'b0000, -8'sd16, 8'sd0, 8'sd0, 8'sd0);
    collect(1'b0);
    vectors++; if (r_bits[3:0] !== 4'b0000) begin miscompares++;
      $display("FAIL zero_bits: got %b want 0000", r_bits[3:0]); end
    vectors++; if (r_nb !== 4) begin miscompares++;
      $display("FAIL zero_count: got %0d want 4", r_nb); end
    vectors++; if (r_lastpos !== 3) begin miscompares++;
      $display("FAIL zero_last_pos: got %0d want 3", r_lastpos); end
    vectors++; if (r_lat !== 6) begin miscompares++;
      $display("FAIL zero_latency: got %0d want 6", r_lat); end
    vectors++; if (r_ferrcnt !== 0) begin miscompares++;
      $display("FAIL zero_frame_err: got %0d pulses want 0", r_ferrcnt); end
    @(negedge clk);
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++;
      $display("FAIL zero_valid_drop: got %b want 0", bus.out_valid); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++;
      $display("FAIL zero_ready_back: got %b want 1", bus.in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_message();
    send_frame(4'b0000, 4'b0000, 4'b0100, 4'b0000, 8'sd5, 8'sd5, 8'sd5, -8'sd20);
    collect(1'b0);
    // Bits in order 1,0,1,1 -> bit index 0 holds the first.
    vectors++; if (r_bits[3:0] !== 4'b1101) begin miscompares++;
      $display("FAIL msg_bits: got %b want 1101", r_bits[3:0]); end
    vectors++; if (r_nb !== 4) begin miscompares++;
      $display("FAIL msg_count: got %0d want 4", r_nb); end
    vectors++; if (r_lastpos !== 3) begin miscompares++;
      $display("FAIL msg_last_pos: got %0d want 3", r_lastpos); end
  endtask

  task automatic test_tie_break();
    send_frame(4'b0000, 4'b0000, 4'b0100, 4'b0000, -8'sd20, 8'sd5, 8'sd5, -8'sd20);
    collect(1'b0);
    vectors++; if (r_bits[3:0] !== 4'b0000) begin miscompares++;
      $display("FAIL tie_bits: got %b want 0000", r_bits[3:0]); end
    vectors++; if (r_nb !== 4) begin miscompares++;
      $display("FAIL tie_count: got %0d want 4", r_nb); end
  endtask

  task automatic test_signed_compare();
    // State 1 wins (-128); trace 1->2->1->2 gives bits 1,0,1,0.
    send_frame(4'b0000, 4'b0000, 4'b0100, 4'b0000, 8'sd100, -8'sd128, 8'sd127, 8'sd0);
    collect(1'b0);
    vectors++; if (r_bits[3:0] !== 4'b0101) begin miscompares++;
      $display("FAIL signed_bits: got %b want 0101", r_bits[3:0]); end
  endtask

  task automatic test_backpressure();
    send_frame(4'b0000, 4'b0000, 4'b0100, 4'b0000, 8'sd5, 8'sd5, 8'sd5, -8'sd20);
    // Junk on the input side while busy must be ignored.
    bus.in_valid = 1'b1; bus.in_dec = 4'b1111; bus.in_last = 1'b1;
    collect(1'b1);
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    vectors++; if (r_bits[3:0] !== 4'b1101) begin miscompares++;
      $display("FAIL bp_bits: got %b want 1101", r_bits[3:0]); end
    vectors++; if (r_nb !== 4) begin miscompares++;
      $display("FAIL bp_count: got %0d want 4", r_nb); end
    vectors++; if (r_lastpos !== 3) begin miscompares++;
      $display("FAIL bp_last_pos: got %0d want 3", r_lastpos); end
    vectors++; if (r_unstable !== 0) begin miscompares++;
      $display("FAIL bp_stable: got %0d changes while stalled want 0", r_unstable); end
    vectors++; if (r_rdyhi !== 0) begin miscompares++;
      $display("FAIL bp_in_ready: got %0d busy cycles with in_ready want 0", r_rdyhi); end
  endtask

  task automatic test_overflow();
    int pre_err;
    pre_err = 0;
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1; bus.in_dec = 4'b0000; bus.in_last = 1'b0;
      if (i == 15) begin
        bus.pm0 = 8'sd5; bus.pm1 = 8'sd5; bus.pm2 = 8'sd5; bus.pm3 = -8'sd20;
      end else begin
        bus.pm0 = -8'sd50; bus.pm1 = 8'sd0; bus.pm2 = 8'sd0; bus.pm3 = 8'sd0;
      end
      @(negedge clk);
      if (bus.frame_err === 1'b1) pre_err++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    collect(1'b0);
    vectors++; if (pre_err !== 0) begin miscompares++;
      $display("FAIL ovf_early_err: got %0d pulses want 0", pre_err); end
    vectors++; if (r_ferrc1 !== 1) begin miscompares++;
      $display("FAIL ovf_err_pulse: got %0d want 1", r_ferrc1); end
    vectors++; if (r_ferrcnt !== 1) begin miscompares++;
      $display("FAIL ovf_err_width: got %0d cycles want 1", r_ferrcnt); end
    vectors++; if (r_bits[15:0] !== 16'hC000) begin miscompares++;
      $display("FAIL ovf_bits: got %h want c000", r_bits[15:0]); end
    vectors++; if (r_nb !== 16) begin miscompares++;
      $display("FAIL ovf_count: got %0d want 16", r_nb); end
    vectors++; if (r_lastpos !== 15) begin miscompares++;
      $display("FAIL ovf_last_pos: got %0d want 15", r_lastpos); end
    vectors++; if (r_lat !== 18) begin miscompares++;
      $display("FAIL ovf_latency: got %0d want 18", r_lat); end
  endtask

  task automatic test_reset_mid_trace();
    send_frame(4'b0000, 4'b0000, 4'b0100, 4'b0000, 8'sd5, 8'sd5, 8'sd5, -8'sd20);
    @(posedge clk); #1;
    @(negedge clk);
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++;
      $display("FAIL rst_busy_ready: got %b want 0", bus.in_ready); end
    rst = 1'b1;
    #1;
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++;
      $display("FAIL rst_async_ready: got %b want 1", bus.in_ready); end
    vectors++; if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0) begin miscompares++;
      $display("FAIL rst_async_out: got valid=%b last=%b want 0/0", bus.out_valid,
               bus.out_last); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    send_frame(4'b0000, 4'b0000, 4'b0100, 4'b0000, 8'sd5, 8'sd5, 8'sd5, -8'sd20);
    collect(1'b0);
    vectors++; if (r_bits[3:0] !== 4'b1101) begin miscompares++;
      $display("FAIL rst_after_bits: got %b want 1101", r_bits[3:0]); end
    vectors++; if (r_lat !== 6) begin miscompares++;
      $display("FAIL rst_after_latency: got %0d want 6", r_lat); end
    vectors++; if (r_lastpos !== 3) begin miscompares++;
      $display("FAIL rst_after_last_pos: got %0d want 3", r_lastpos); end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_dec = 4'b0000; bus.in_last = 1'b0;
    bus.pm0 = '0; bus.pm1 = '0; bus.pm2 = '0; bus.pm3 = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_all_zero();
    test_message();
    test_tie_break();
    test_signed_compare();
    test_backpressure();
    test_overflow();
    test_reset_mid_trace();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/viterbi_traceback.md
Name: viterbi_traceback

Overview:
- Downstream consumer of the butterfly edge/survivor stages in the K=3, rate-1/2 Viterbi decoder (4 trellis states).
- Buffers one frame of per-stage survivor decisions and the final path metrics.
- Selects the best end state, traces back through the stored decisions, and emits the decoded bits in forward order over a valid/ready handshake.

Parameters:
- FRAME_LEN, 16, maximum number of trellis stages per frame (legal range 2..64).
- PM_W, 8, path-metric width; signed two's complement, smaller value is the shorter path.
- AW, 6, decision-buffer address width; must satisfy 2**AW >= FRAME_LEN.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- in_valid  in  1  stage decision vector present.
- in_ready  out  1  block accepts a stage this cycle.
- in_dec  in  4  survivor decision per state; bit s = predecessor LSB chosen for state s.
- in_last  in  1  marks the final stage of the frame.
- pm0..pm3  in  PM_W each  path metrics of states 0..3; sampled only on the in_last beat.
- out_valid  out  1  decoded bit available.
- out_ready  in  1  downstream accepts the bit.
- out_bit  out  1  decoded information bit.
- out_last  out  1  high with the frame's final decoded bit.
- frame_err  out  1  one-cycle pulse when FRAME_LEN stages arrive without in_last.

Behaviour:
- State encoding: s = {newest bit, older bit}.
  - Next state s' = {u, s[1]}.
  - Predecessor of s' = {s'[0], in_dec[s']}.
  - Decoded bit for the stage ending in s' is s'[1].
- Reset (asynchronous, any state):
  - FSM goes to COLLECT; stage count = 0.
  - in_ready=1; out_valid=0, out_bit=0, out_last=0, frame_err=0.
  - Buffer contents are don't-care.
  - A frame in progress is discarded.
- COLLECT:
  - in_ready=1.
  - On in_valid: write in_dec to buf[cnt], then cnt++.
  - If in_last, or cnt reaches FRAME_LEN-1 without in_last:
    - latch N = cnt+1;
    - register pm0..pm3 (on overflow use the pm values present that beat);
    - go to SELECT.
  - Overflow additionally pulses frame_err for one cycle.
- SELECT (1 cycle):
  - in_ready=0.
  - cur = index of the minimum signed metric; ties go to the lowest index.
  - ptr = N-1. Go to TRACE.
- TRACE (N cycles, one stage per cycle):
  - obuf[ptr] = cur[1].
  - cur = {cur[0], buf[ptr][cur]}.
  - On ptr==0 go to EMIT with rd=0; otherwise ptr--.
- EMIT:
  - out_valid=1, out_bit=obuf[rd], out_last=(rd==N-1).
  - rd advances only when out_valid && out_ready.
  - out_bit/out_last hold stable while out_ready=0.
  - After the last handshake, out_valid=0 next cycle and go to COLLECT with cnt=0.
- in_ready is 0 in SELECT/TRACE/EMIT; in_valid there is ignored, no data loss is permitted upstream-side.
- Frame latency: first out_valid = N+2 cycles after the in_last beat.
- Single-stage frame (N=1): SELECT, one TRACE cycle, one EMIT beat with out_last=1.
- Metric compare is a full PM_W signed compare. No saturation is needed; normalisation is upstream.

Decomposition:
- Shared package viterbi_pkg:
  - NUM_STATES=4;
  - state width 2;
  - PM_W default;
  - FSM state enum COLLECT/SELECT/TRACE/EMIT;
  - next-state/predecessor helper functions.
- One natural sub-module: viterbi_min4, a combinational argmin of four signed PM_W metrics with lowest-index tie-break.
- Decision and output buffers are inferred register arrays inside viterbi_traceback.

Test Plan:
- All-zero frame: 4 stages, in_dec=0000 each, last pm={-16,0,0,0} -> out bits 0,0,0,0; out_last on 4th; first out_valid 6 cycles after in_last.
- Message 1011: in_dec stages 0000,0000,0100,0000; pm3=-20, others=5 -> out bits 1,0,1,1 in order.
- Tie-break: frame as above with pm0=pm3=-20, pm1=pm2=5 -> trace starts at state 0, output 0,0,0,0.
- Backpressure: out_ready toggled 0/1 every cycle during EMIT -> each bit held stable until accepted; no bit dropped or duplicated; in_ready=0 throughout.
- Overflow: FRAME_LEN=16 stages, in_last never asserted -> frame_err pulses on the 16th beat; 16 bits emitted; out_last on 16th.
- Reset mid-TRACE: assert RST for one cycle -> outputs go to reset values immediately; next 4-stage frame decodes correctly.
